regfile_wb_bypass: RTL

//   Register file for the pipelined CPU: the write-back (MEM/WB) side that updates

---
 rtl/regfile_wb_bypass.sv | 70 +++++++
 1 files changed

// File: rtl/regfile_wb_bypass.sv
// regfile_wb_bypass: write-back register file, two decode read ports with
// write-through bypass; the top register (XZR) always reads zero.
module regfile_wb_bypass #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              bypass1,
  output logic              bypass2
);

  localparam logic [ADDR_W:0] XZR = (ADDR_W+1)'(NUM_REGS - 1);

  logic [NUM_REGS-1:0][DATA_W-1:0] mem;
  logic                            wr_en;

  // XZR and out-of-range destinations fall outside the writable window
  assign wr_en = RegWrite && ({1'b0, WriteRegister} < XZR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[WriteRegister] <= WriteData;
    end
  end

  logic [1:0][ADDR_W-1:0] rd_addr;

  assign rd_addr = {ReadRegister2, ReadRegister1};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic              in_rng;
    logic              hit;
    logic [DATA_W-1:0] data;
    logic              byp;

    assign in_rng = {1'b0, rd_addr[p]} < XZR;
    assign hit    = RegWrite && (WriteRegister == rd_addr[p]);

    // zero-register check outranks the bypass
    always_comb begin
      data = '0;
      byp  = 1'b0;
      if (reset && in_rng) begin
        if (hit) begin
          data = WriteData;
          byp  = 1'b1;
        end else begin
          data = mem[rd_addr[p]];
        end
      end
    end
  end

  assign ReadData1 = g_rd[0].data;
  assign ReadData2 = g_rd[1].data;
  assign bypass1   = g_rd[0].byp;
  assign bypass2   = g_rd[1].byp;

endmodule
